bp_cfg_sequencer: RTL and testbench

Parametrised configuration sequencer that moves host config commands onto per-core config ports for an arbitrary number of cores.
Supports unicast write, broadcast write (sequenced core 0..N-1), and unicast read with response and timeout.
Sits between the host/NoC config endpoint and each core's config register block; replaces fixed-core-count config plumbing.

---
 rtl/bp_cfg_sequencer.sv | 168 ++++++++++++++++
 tb/tb_bp_cfg_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_sequencer.sv
// bp_cfg_sequencer: moves host config commands onto per-core config ports.
// Unicast/broadcast writes; unicast reads return one response, with a timeout.
//   state  | meaning
//   IDLE   | waiting for a host command
//   ISSUE  | presenting request to core r_ptr
//   WAIT   | read issued, waiting for read data or timeout
//   RESP   | read response held until host accepts
module bp_cfg_sequencer #(
  parameter int num_core_p       = 1,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int timeout_p        = 255,
  localparam int core_width_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1,
  localparam int tcnt_width_lp   = (timeout_p > 1) ? $clog2(timeout_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   cmd_v_i,
  output logic                                   cmd_ready_o,
  input  logic                                   cmd_w_i,
  input  logic                                   cmd_bcast_i,
  input  logic [core_width_lp-1:0]               cmd_core_i,
  input  logic [cfg_addr_width_p-1:0]            cmd_addr_i,
  input  logic [cfg_data_width_p-1:0]            cmd_data_i,
  output logic [num_core_p-1:0]                  cfg_v_o,
  output logic                                   cfg_w_o,
  output logic [cfg_addr_width_p-1:0]            cfg_addr_o,
  output logic [cfg_data_width_p-1:0]            cfg_data_o,
  input  logic [num_core_p-1:0]                  cfg_ready_i,
  input  logic [num_core_p-1:0]                  cfg_rdata_v_i,
  input  logic [num_core_p*cfg_data_width_p-1:0] cfg_rdata_i,
  output logic                                   resp_v_o,
  output logic [cfg_data_width_p-1:0]            resp_data_o,
  output logic                                   resp_err_o,
  input  logic                                   resp_ready_i,
  output logic                                   busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                      r_state, w_state_nxt;
  logic                        r_w, r_bcast;
  logic [core_width_lp-1:0]    r_ptr;
  logic [cfg_addr_width_p-1:0] r_addr;
  logic [cfg_data_width_p-1:0] r_data, r_resp_data;
  logic                        r_resp_err;
  logic [tcnt_width_lp-1:0]    r_tcnt;

  logic [num_core_p-1:0]       w_sel;
  logic [cfg_data_width_p-1:0] w_rdata_sel;
  logic                        w_bad_core, w_ready_sel, w_rdata_hit, w_last_core, w_timeout;

  // One-hot decode of the current core plus its read-data slice.
  always_comb begin
    w_sel       = '0;
    w_rdata_sel = '0;
    for (int i = 0; i < num_core_p; i++) begin
      if (r_ptr == core_width_lp'(i)) begin
        w_sel[i]    = 1'b1;
        w_rdata_sel = cfg_rdata_i[i*cfg_data_width_p +: cfg_data_width_p];
      end
    end
  end

  assign w_bad_core  = ~(cmd_bcast_i & cmd_w_i) &
                       ({1'b0, cmd_core_i} >= (core_width_lp+1)'(num_core_p));
  assign w_ready_sel = |(cfg_ready_i & w_sel);
  assign w_rdata_hit = |(cfg_rdata_v_i & w_sel);
  assign w_last_core = (r_ptr == core_width_lp'(num_core_p - 1));
  assign w_timeout   = (r_tcnt == tcnt_width_lp'(timeout_p - 1));

  assign cfg_w_o     = r_w;
  assign cfg_addr_o  = r_addr;
  assign cfg_data_o  = r_data;
  assign resp_data_o = r_resp_data;
  assign resp_err_o  = r_resp_err;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    resp_v_o    = 1'b0;
    cfg_v_o     = '0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_v_i) begin
          if (!w_bad_core)   w_state_nxt = S_ISSUE;
          else if (!cmd_w_i) w_state_nxt = S_RESP;
        end
      end
      S_ISSUE: begin
        cfg_v_o = w_sel;
        if (w_ready_sel) begin
          // Read data arriving alongside the accept skips WAIT entirely.
          if (!r_w)                     w_state_nxt = w_rdata_hit ? S_RESP : S_WAIT;
          else if (!r_bcast || w_last_core) w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (w_rdata_hit || w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_v_o = 1'b1;
        if (resp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_w         <= 1'b0;
      r_bcast     <= 1'b0;
      r_ptr       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
      r_tcnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_v_i) begin
            r_w     <= cmd_w_i;
            r_bcast <= cmd_bcast_i;
            r_addr  <= cmd_addr_i;
            r_data  <= cmd_data_i;
            r_ptr   <= (cmd_bcast_i & cmd_w_i) ? '0 : cmd_core_i;
            if (w_bad_core) begin
              r_resp_data <= '1;
              r_resp_err  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_ready_sel) begin
            r_tcnt <= '0;
            if (r_w && r_bcast && !w_last_core) r_ptr <= r_ptr + 1'b1;
            if (!r_w && w_rdata_hit) begin
              r_resp_data <= w_rdata_sel;
              r_resp_err  <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (w_rdata_hit) begin
            r_resp_data <= w_rdata_sel;
            r_resp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_resp_data <= '1;
            r_resp_err  <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Scoreboard bench for bp_cfg_sequencer: a 4-core instance (timeout 8) and a
// 3-core instance for out-of-range core handling.
module tb_bp_cfg_sequencer;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic          cmd_w, cmd_bcast, cmd_v4, cmd_v3;
  logic [1:0]    cmd_core;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;

  logic            cmd_ready4, cfg_w4, resp_v4, resp_err4, busy4, resp_ready4;
  logic [3:0]      cfg_v4, cfg_ready4, rdata_v4;
  logic [AW-1:0]   cfg_addr4;
  logic [DW-1:0]   cfg_data4, resp_data4;
  logic [4*DW-1:0] rdata4;

  logic            cmd_ready3, cfg_w3, resp_v3, resp_err3, busy3, resp_ready3;
  logic [2:0]      cfg_v3, cfg_ready3, rdata_v3;
  logic [AW-1:0]   cfg_addr3;
  logic [DW-1:0]   cfg_data3, resp_data3;
  logic [3*DW-1:0] rdata3;

  bp_cfg_sequencer #(.num_core_p(4), .cfg_addr_width_p(AW), .cfg_data_width_p(DW), .timeout_p(8)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .cmd_v_i(cmd_v4), .cmd_ready_o(cmd_ready4), .cmd_w_i(cmd_w),
    .cmd_bcast_i(cmd_bcast), .cmd_core_i(cmd_core), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .cfg_v_o(cfg_v4), .cfg_w_o(cfg_w4), .cfg_addr_o(cfg_addr4), .cfg_data_o(cfg_data4),
    .cfg_ready_i(cfg_ready4), .cfg_rdata_v_i(rdata_v4), .cfg_rdata_i(rdata4),
    .resp_v_o(resp_v4), .resp_data_o(resp_data4), .resp_err_o(resp_err4),
    .resp_ready_i(resp_ready4), .busy_o(busy4));

  bp_cfg_sequencer #(.num_core_p(3), .cfg_addr_width_p(AW), .cfg_data_width_p(DW), .timeout_p(8)) u_dut3 (
    .clk_i(clk), .reset_i(rst), .cmd_v_i(cmd_v3), .cmd_ready_o(cmd_ready3), .cmd_w_i(cmd_w),
    .cmd_bcast_i(cmd_bcast), .cmd_core_i(cmd_core), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .cfg_v_o(cfg_v3), .cfg_w_o(cfg_w3), .cfg_addr_o(cfg_addr3), .cfg_data_o(cfg_data3),
    .cfg_ready_i(cfg_ready3), .cfg_rdata_v_i(rdata_v3), .cfg_rdata_i(rdata3),
    .resp_v_o(resp_v3), .resp_data_o(resp_data3), .resp_err_o(resp_err3),
    .resp_ready_i(resp_ready3), .busy_o(busy3));

  typedef struct {
    int            cyc;
    logic [3:0]    v;
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  beat_t q_beat4[$], q_beat3[$];
  resp_t q_resp4[$], q_resp3[$];
  beat_t eb;
  resp_t er;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm, input logic [DW-1:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h expected nothing (cycle %0d)", nm, act, cyc);
  endtask

  task automatic push_beat(input bit d3, input int c, input logic [3:0] v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    beat_t b;
    b.cyc = c; b.v = v; b.w = w; b.addr = a; b.data = d;
    if (d3) q_beat3.push_back(b);
    else    q_beat4.push_back(b);
  endtask

  task automatic push_resp(input bit d3, input int c, input logic [DW-1:0] d, input logic e);
    resp_t r;
    r.cyc = c; r.data = d; r.err = e;
    if (d3) q_resp3.push_back(r);
    else    q_resp4.push_back(r);
  endtask

  // Monitor: every cycle a request or response is presented, pop and compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_v4 != 4'b0) begin
        if (q_beat4.size() == 0) flag("beat4_unexpected", {60'b0, cfg_v4});
        else begin
          eb = q_beat4.pop_front();
          check("beat4_cyc", DW'(cyc), DW'(eb.cyc));
          check("beat4_v", {60'b0, cfg_v4}, {60'b0, eb.v});
          check("beat4_w", {63'b0, cfg_w4}, {63'b0, eb.w});
          check("beat4_addr", {48'b0, cfg_addr4}, {48'b0, eb.addr});
          check("beat4_data", cfg_data4, eb.data);
        end
      end
      if (cfg_v3 != 3'b0) begin
        if (q_beat3.size() == 0) flag("beat3_unexpected", {61'b0, cfg_v3});
        else begin
          eb = q_beat3.pop_front();
          check("beat3_cyc", DW'(cyc), DW'(eb.cyc));
          check("beat3_v", {61'b0, cfg_v3}, {60'b0, eb.v});
          check("beat3_w", {63'b0, cfg_w3}, {63'b0, eb.w});
          check("beat3_addr", {48'b0, cfg_addr3}, {48'b0, eb.addr});
          check("beat3_data", cfg_data3, eb.data);
        end
      end
      if (resp_v4) begin
        if (q_resp4.size() == 0) flag("resp4_unexpected", resp_data4);
        else begin
          er = q_resp4.pop_front();
          check("resp4_cyc", DW'(cyc), DW'(er.cyc));
          check("resp4_data", resp_data4, er.data);
          check("resp4_err", {63'b0, resp_err4}, {63'b0, er.err});
        end
      end
      if (resp_v3) begin
        if (q_resp3.size() == 0) flag("resp3_unexpected", resp_data3);
        else begin
          er = q_resp3.pop_front();
          check("resp3_cyc", DW'(cyc), DW'(er.cyc));
          check("resp3_data", resp_data3, er.data);
          check("resp3_err", {63'b0, resp_err3}, {63'b0, er.err});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit d3, input logic w, input logic b, input logic [1:0] core,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_w = w; cmd_bcast = b; cmd_core = core; cmd_addr = a; cmd_data = d;
    if (d3) cmd_v3 = 1'b1;
    else    cmd_v4 = 1'b1;
    @(posedge clk);
    #1;
    cmd_v3 = 1'b0;
    cmd_v4 = 1'b0;
  endtask

  // Samples handshake status in the current cycle, then advances one cycle.
  task automatic expect_state(input bit d3, input logic rdy);
    @(negedge clk);
    if (d3) begin
      check("cmd_ready3", {63'b0, cmd_ready3}, {63'b0, rdy});
      check("busy3", {63'b0, busy3}, {63'b0, ~rdy});
    end else begin
      check("cmd_ready4", {63'b0, cmd_ready4}, {63'b0, rdy});
      check("busy4", {63'b0, busy4}, {63'b0, ~rdy});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a;
    rst = 1'b1;
    cmd_v4 = 1'b0; cmd_v3 = 1'b0; cmd_w = 1'b0; cmd_bcast = 1'b0; cmd_core = 2'd0;
    cmd_addr = '0; cmd_data = '0;
    cfg_ready4 = 4'hF; rdata_v4 = 4'h0; rdata4 = '0; resp_ready4 = 1'b1;
    cfg_ready3 = 3'h7; rdata_v3 = 3'h0; rdata3 = '0; resp_ready3 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready4", {63'b0, cmd_ready4}, 64'd1);
    check("rst_busy4", {63'b0, busy4}, 64'd0);
    check("rst_cfg_v4", {60'b0, cfg_v4}, 64'd0);
    check("rst_resp_v4", {63'b0, resp_v4}, 64'd0);
    check("rst_cfg_addr4", {48'b0, cfg_addr4}, 64'd0);
    check("rst_resp_data4", resp_data4, 64'd0);
    check("rst_cmd_ready3", {63'b0, cmd_ready3}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);

    // Unicast write core 2
    a = cyc;
    push_beat(0, a + 1, 4'b0100, 1'b1, 16'h10, 64'hDEAD);
    send(0, 1'b1, 1'b0, 2'd2, 16'h10, 64'hDEAD);
    expect_state(0, 1'b0);
    expect_state(0, 1'b1);

    // Broadcast write, core 1 stalls three cycles
    cfg_ready4 = 4'b1101;
    a = cyc;
    push_beat(0, a + 1, 4'b0001, 1'b1, 16'h4, 64'h1);
    for (int k = 2; k <= 5; k++) push_beat(0, a + k, 4'b0010, 1'b1, 16'h4, 64'h1);
    push_beat(0, a + 6, 4'b0100, 1'b1, 16'h4, 64'h1);
    push_beat(0, a + 7, 4'b1000, 1'b1, 16'h4, 64'h1);
    send(0, 1'b1, 1'b1, 2'd0, 16'h4, 64'h1);
    tick(4);
    cfg_ready4 = 4'hF;
    tick(3);
    expect_state(0, 1'b1);

    // Unicast read core 3, data five cycles after request, host stalls response
    resp_ready4 = 1'b0;
    rdata4[2*DW +: DW] = 64'h9999;
    rdata4[3*DW +: DW] = 64'h1234;
    a = cyc;
    push_beat(0, a + 1, 4'b1000, 1'b0, 16'h20, 64'h0);
    for (int k = 7; k <= 9; k++) push_resp(0, a + k, 64'h1234, 1'b0);
    send(0, 1'b0, 1'b0, 2'd3, 16'h20, 64'h0);
    expect_state(0, 1'b0);
    tick(4);
    rdata_v4 = 4'b1000;
    tick(1);
    rdata_v4 = 4'b0000;
    rdata4[3*DW +: DW] = 64'hFFFF_0000;
    tick(2);
    resp_ready4 = 1'b1;
    tick(1);
    expect_state(0, 1'b1);

    // Read core 0 times out; core 1 read data ignored
    rdata4[1*DW +: DW] = 64'h5555;
    a = cyc;
    push_beat(0, a + 1, 4'b0001, 1'b0, 16'h30, 64'h0);
    push_resp(0, a + 10, ONES, 1'b1);
    send(0, 1'b0, 1'b0, 2'd0, 16'h30, 64'h0);
    tick(2);
    rdata_v4 = 4'b0010;
    tick(3);
    rdata_v4 = 4'b0000;
    tick(4);
    expect_state(0, 1'b0);
    expect_state(0, 1'b1);

    // Read data in the last timeout cycle wins
    rdata4[2*DW +: DW] = 64'hCAFE;
    a = cyc;
    push_beat(0, a + 1, 4'b0100, 1'b0, 16'h40, 64'h0);
    push_resp(0, a + 10, 64'hCAFE, 1'b0);
    send(0, 1'b0, 1'b0, 2'd2, 16'h40, 64'h0);
    tick(8);
    rdata_v4 = 4'b0100;
    tick(1);
    rdata_v4 = 4'b0000;
    tick(1);
    expect_state(0, 1'b1);

    // Read data valid in the same cycle the request is accepted
    rdata4[1*DW +: DW] = 64'hBEEF;
    a = cyc;
    push_beat(0, a + 1, 4'b0010, 1'b0, 16'h50, 64'h0);
    push_resp(0, a + 2, 64'hBEEF, 1'b0);
    send(0, 1'b0, 1'b0, 2'd1, 16'h50, 64'h0);
    rdata_v4 = 4'b0010;
    tick(1);
    rdata_v4 = 4'b0000;
    tick(1);
    expect_state(0, 1'b1);

    // Reset while broadcast is stalled at core 2
    cfg_ready4 = 4'b1011;
    a = cyc;
    push_beat(0, a + 1, 4'b0001, 1'b1, 16'h60, 64'h77);
    push_beat(0, a + 2, 4'b0010, 1'b1, 16'h60, 64'h77);
    push_beat(0, a + 3, 4'b0100, 1'b1, 16'h60, 64'h77);
    send(0, 1'b1, 1'b1, 2'd0, 16'h60, 64'h77);
    tick(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_cfg_v4", {60'b0, cfg_v4}, 64'd0);
    check("midrst_cmd_ready4", {63'b0, cmd_ready4}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cfg_ready4 = 4'hF;
    tick(1);
    expect_state(0, 1'b1);
    expect_state(0, 1'b1);

    // 3-core instance: read of core 3 errors without any request
    a = cyc;
    push_resp(1, a + 1, ONES, 1'b1);
    send(1, 1'b0, 1'b0, 2'd3, 16'h70, 64'h0);
    expect_state(1, 1'b0);
    expect_state(1, 1'b1);

    // Write to core 3 is dropped
    send(1, 1'b1, 1'b0, 2'd3, 16'h80, 64'h42);
    expect_state(1, 1'b1);

    // Valid unicast write to the last core
    a = cyc;
    push_beat(1, a + 1, 4'b0100, 1'b1, 16'h90, 64'h99);
    send(1, 1'b1, 1'b0, 2'd2, 16'h90, 64'h99);
    expect_state(1, 1'b0);
    expect_state(1, 1'b1);

    // Broadcast always starts at core 0 regardless of core field
    a = cyc;
    push_beat(1, a + 1, 4'b0001, 1'b1, 16'hA0, 64'hA5);
    push_beat(1, a + 2, 4'b0010, 1'b1, 16'hA0, 64'hA5);
    push_beat(1, a + 3, 4'b0100, 1'b1, 16'hA0, 64'hA5);
    send(1, 1'b1, 1'b1, 2'd1, 16'hA0, 64'hA5);
    tick(2);
    expect_state(1, 1'b0);
    expect_state(1, 1'b1);

    tick(3);
    check("beat4_left", DW'(q_beat4.size()), 64'd0);
    check("beat3_left", DW'(q_beat3.size()), 64'd0);
    check("resp4_left", DW'(q_resp4.size()), 64'd0);
    check("resp3_left", DW'(q_resp3.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
